eth_axis_tx: RTL and testbench

//  AXI4-Stream Ethernet frame transmitter: accepts parallel header fields (dest MAC, src MAC, ethertype)

---
 rtl/eth_axis_tx_pkg.sv | 31 +++
 rtl/eth_axis_tx_skid.sv | 48 ++++
 rtl/eth_axis_tx.sv | 186 ++++++++++++++++++
 tb/tb_eth_axis_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_tx_pkg.sv
// Shared Ethernet TX definitions: header geometry, FSM state type and header byte packing.
package eth_axis_tx_pkg;

  localparam int unsigned ETH_HDR_LEN     = 14;
  localparam int unsigned ETH_DEST_OFFSET = 0;
  localparam int unsigned ETH_SRC_OFFSET  = 6;
  localparam int unsigned ETH_TYPE_OFFSET = 12;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StExtra
  } tx_state_e;

  // Header byte k lands at [8k+:8], i.e. in wire order from the LSB up.
  function automatic logic [8*ETH_HDR_LEN-1:0] eth_hdr_pack(input logic [47:0] dest_mac,
                                                            input logic [47:0] src_mac,
                                                            input logic [15:0] eth_type);
    logic [8*ETH_HDR_LEN-1:0] hdr;
    hdr = '0;
    for (int k = 0; k < 6; k++) begin
      hdr[8*(ETH_DEST_OFFSET+k) +: 8] = dest_mac[8*(5-k) +: 8];
      hdr[8*(ETH_SRC_OFFSET+k) +: 8]  = src_mac[8*(5-k) +: 8];
    end
    hdr[8*ETH_TYPE_OFFSET +: 8]     = eth_type[15:8];
    hdr[8*(ETH_TYPE_OFFSET+1) +: 8] = eth_type[7:0];
    return hdr;
  endfunction

endpackage

// File: rtl/eth_axis_tx_skid.sv
// Two-entry AXI-stream register slice; upstream ready is registered so there is no
// combinational path from m_ready back to s_ready.
module axis_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [Width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [Width-1:0] temp_data_q;
  logic             temp_valid_q;
  logic             ready_early;

  // Accept next cycle if downstream drains, or if nothing would need the temp slot.
  assign ready_early = m_ready || (!temp_valid_q && (!m_valid || !s_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      temp_valid_q <= 1'b0;
      temp_data_q  <= '0;
    end else begin
      s_ready <= ready_early;
      if (s_ready) begin
        if (m_ready || !m_valid) begin
          m_data  <= s_data;
          m_valid <= s_valid;
        end else begin
          temp_data_q  <= s_data;
          temp_valid_q <= s_valid;
        end
      end else if (m_ready) begin
        m_data       <= temp_data_q;
        m_valid      <= temp_valid_q;
        temp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/eth_axis_tx.sv
// Ethernet frame transmitter: prepends the 14-byte header to a payload AXI stream,
// realigning payload lanes when the header does not fill a whole number of words.
module eth_axis_tx
  import eth_axis_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);

  localparam int unsigned HDR_CYCLES = (ETH_HDR_LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int unsigned OFFSET     = ETH_HDR_LEN % KEEP_WIDTH;
  // Words carrying only header bytes; a partial tail word is merged with payload.
  localparam int unsigned HDR_WORDS  = HDR_CYCLES - ((OFFSET != 0) ? 1 : 0);
  localparam int unsigned HdrPadW    = 8 * ETH_HDR_LEN + DATA_WIDTH;
  localparam int unsigned SkidWidth  = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [KEEP_WIDTH-1:0] TailKeep = {KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - OFFSET);

  if ((DATA_WIDTH % 8 != 0) || (KEEP_WIDTH * 8 != DATA_WIDTH)) begin : g_width_check
    $error("eth_axis_tx: DATA_WIDTH must be a multiple of 8 and match KEEP_WIDTH");
  end

  tx_state_e                 state_q;
  logic [3:0]                ptr_q;
  logic [8*ETH_HDR_LEN-1:0]  hdr_q;
  logic [DATA_WIDTH-1:0]     save_data_q;
  logic [KEEP_WIDTH-1:0]     save_keep_q;
  logic                      tuser_q;
  logic                      hdr_ready_q;
  logic                      busy_q;

  logic [8*ETH_HDR_LEN-1:0]  hdr_in;
  logic [HdrPadW-1:0]        hdr_in_pad;
  logic [HdrPadW-1:0]        hdr_q_pad;
  logic [KEEP_WIDTH-1:0]     pl_keep;
  logic                      pl_fire;
  logic                      pl_extra;

  logic                      int_ready;
  logic                      int_valid;
  logic [DATA_WIDTH-1:0]     int_data;
  logic [KEEP_WIDTH-1:0]     int_keep;
  logic                      int_last;
  logic                      int_user;
  logic [SkidWidth-1:0]      skid_out;
  logic [KEEP_WIDTH-1:0]     skid_keep;

  assign hdr_in     = eth_hdr_pack(s_eth_dest_mac, s_eth_src_mac, s_eth_type);
  assign hdr_in_pad = {{DATA_WIDTH{1'b0}}, hdr_in};
  assign hdr_q_pad  = {{DATA_WIDTH{1'b0}}, hdr_q};
  assign pl_keep    = KEEP_ENABLE ? s_eth_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};

  assign s_eth_hdr_ready           = hdr_ready_q;
  assign busy                      = busy_q;
  assign s_eth_payload_axis_tready = int_ready && (state_q == StPayload);
  assign pl_fire  = s_eth_payload_axis_tready && s_eth_payload_axis_tvalid;
  // Bytes shifted past the top lane spill into one more output word.
  assign pl_extra = |(pl_keep >> (KEEP_WIDTH - OFFSET));

  always_comb begin
    int_valid = 1'b0;
    int_data  = '0;
    int_keep  = '0;
    int_last  = 1'b0;
    int_user  = 1'b0;
    unique case (state_q)
      StHeader: begin
        int_valid = int_ready;
        int_data  = hdr_q_pad[ptr_q * DATA_WIDTH +: DATA_WIDTH];
        int_keep  = {KEEP_WIDTH{1'b1}};
      end
      StPayload: begin
        int_valid = pl_fire;
        int_data  = (s_eth_payload_axis_tdata << (8 * OFFSET)) | save_data_q;
        int_keep  = (pl_keep << OFFSET) | save_keep_q;
        int_last  = s_eth_payload_axis_tlast && !pl_extra;
        int_user  = s_eth_payload_axis_tlast && !pl_extra && s_eth_payload_axis_tuser;
      end
      StExtra: begin
        int_valid = int_ready;
        int_data  = save_data_q;
        int_keep  = save_keep_q;
        int_last  = 1'b1;
        int_user  = tuser_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hdr_q       <= '0;
      save_data_q <= '0;
      save_keep_q <= '0;
      tuser_q     <= 1'b0;
      hdr_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hdr_ready_q <= 1'b1;
          if (s_eth_hdr_valid && hdr_ready_q) begin
            hdr_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            hdr_q       <= hdr_in;
            ptr_q       <= '0;
            // Preload the header tail so the first payload word merges like any other.
            save_data_q <= hdr_in_pad[HDR_WORDS * DATA_WIDTH +: DATA_WIDTH];
            save_keep_q <= TailKeep;
            state_q     <= (HDR_WORDS != 0) ? StHeader : StPayload;
          end
        end
        StHeader: begin
          if (int_ready) begin
            ptr_q <= ptr_q + 4'd1;
            if (ptr_q == 4'(HDR_WORDS - 1)) state_q <= StPayload;
          end
        end
        StPayload: begin
          if (pl_fire) begin
            save_data_q <= s_eth_payload_axis_tdata >> (DATA_WIDTH - 8 * OFFSET);
            save_keep_q <= pl_keep >> (KEEP_WIDTH - OFFSET);
            if (s_eth_payload_axis_tlast) begin
              if (pl_extra) begin
                tuser_q <= s_eth_payload_axis_tuser;
                state_q <= StExtra;
              end else begin
                state_q     <= StIdle;
                hdr_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end
          end
        end
        StExtra: begin
          if (int_ready) begin
            state_q     <= StIdle;
            hdr_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_skid_reg #(
    .Width(SkidWidth)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_data ({int_data, int_keep, int_last, int_user}),
    .s_valid(int_valid),
    .s_ready(int_ready),
    .m_data (skid_out),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign {m_axis_tdata, skid_keep, m_axis_tlast, m_axis_tuser} = skid_out;
  assign m_axis_tkeep = KEEP_ENABLE ? skid_keep : {KEEP_WIDTH{1'b1}};

endmodule

// File: tb/tb_eth_axis_tx.sv
// Randomized bench for eth_axis_tx at 64-bit width against a byte-level frame model.
module tb_eth_axis_tx;

  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_hdr_valid, s_hdr_ready;
  logic [47:0]   s_dest, s_src;
  logic [15:0]   s_type;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          busy;

  eth_axis_tx #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_eth_hdr_valid          (s_hdr_valid),
    .s_eth_hdr_ready          (s_hdr_ready),
    .s_eth_dest_mac           (s_dest),
    .s_eth_src_mac            (s_src),
    .s_eth_type               (s_type),
    .s_eth_payload_axis_tdata (s_tdata),
    .s_eth_payload_axis_tkeep (s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast (s_tlast),
    .s_eth_payload_axis_tuser (s_tuser),
    .m_axis_tdata             (m_tdata),
    .m_axis_tkeep             (m_tkeep),
    .m_axis_tvalid            (m_tvalid),
    .m_axis_tready            (m_tready),
    .m_axis_tlast             (m_tlast),
    .m_axis_tuser             (m_tuser),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    gap_cnt = 0;
  bit    mon_en = 1'b0;
  bit    rand_ready = 1'b0;
  bit    gap_en = 1'b0;
  bit    in_frame = 1'b0;
  bit    prev_stall = 1'b0;
  logic [73:0] prev_word;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame on the wire = 14 header bytes then payload bytes, packed LSB lane first.
  task automatic model_frame(input logic [47:0] dest, input logic [47:0] src,
                             input logic [15:0] et, input logic [7:0] pl[$], input bit user);
    logic [7:0] b[$];
    word_t w;
    int nw;
    for (int k = 0; k < 6; k++) b.push_back(dest[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) b.push_back(src[47-8*k -: 8]);
    b.push_back(et[15:8]);
    b.push_back(et[7:0]);
    foreach (pl[i]) b.push_back(pl[i]);
    nw = (b.size() + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      w.data = '0;
      w.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (i * 8 + j < b.size()) begin
          w.data[8*j +: 8] = b[i*8+j];
          w.keep[j] = 1'b1;
        end
      end
      w.last = (i == nw - 1);
      w.user = w.last && user;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    logic [63:0] mask;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mon_en) begin
      if (prev_stall)
        check("stable", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, {1'b1, prev_word});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          mask = '0;
          for (int j = 0; j < 8; j++) if (e.keep[j]) mask[8*j +: 8] = 8'hFF;
          check("word", {m_tlast, m_tuser, m_tkeep, m_tdata & mask},
                {e.last, e.user, e.keep, e.data});
        end
        in_frame = !m_tlast;
      end else if (in_frame && gap_en && !m_tvalid) begin
        gap_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tdata, m_tkeep, m_tlast, m_tuser};
    end else begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end
  end

  task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                            input logic [15:0] et, input logic [7:0] pl[$], input bit user,
                            input bit gaps, input int abort_word);
    int nw;
    int to;
    if (abort_word < 0) model_frame(dest, src, et, pl, user);
    s_hdr_valid = 1'b1;
    s_dest = dest;
    s_src  = src;
    s_type = et;
    to = 0;
    while (!s_hdr_ready && to < 2000) begin
      @(negedge clk);
      to++;
    end
    if (!s_hdr_ready) begin
      check("hdr_timeout", s_hdr_ready, 1'b1);
      s_hdr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_hdr_valid = 1'b0;
    s_dest = '1;
    s_src  = '1;
    s_type = '1;
    check("busy_set", busy, 1'b1);
    check("hdr_held", s_hdr_ready, 1'b0);
    nw = (pl.size() + 7) / 8;
    if (nw == 0) nw = 1;
    for (int w = 0; w < nw; w++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      s_tdata = {$urandom, $urandom};
      s_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (w * 8 + j < pl.size()) begin
          s_tdata[8*j +: 8] = pl[w*8+j];
          s_tkeep[j] = 1'b1;
        end
      end
      s_tlast  = (w == nw - 1);
      s_tuser  = s_tlast ? user : 1'($urandom_range(0, 1));
      s_tvalid = 1'b1;
      to = 0;
      while (!s_tready && to < 2000) begin
        @(negedge clk);
        to++;
      end
      if (!s_tready) begin
        check("pl_timeout", s_tready, 1'b1);
        s_tvalid = 1'b0;
        return;
      end
      if (w == abort_word) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pl_ready", s_tready, 1'b0);
        return;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    while (exp_q.size() != 0 && to < 5000) begin
      @(negedge clk);
      to++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  localparam logic [47:0] DEST = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC  = 48'h5A_51_52_53_54_55;
  localparam logic [15:0] TYPE = 16'h0800;

  initial begin
    logic [7:0] pl[$];
    int len;
    s_hdr_valid = 1'b0;
    s_dest = '0;
    s_src = '0;
    s_type = '0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hdr_ready", s_hdr_ready, 1'b0);
    check("rst_pl_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tuser", m_tuser, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("hdr_ready_rise", s_hdr_ready, 1'b1);
    mon_en = 1'b1;
    gap_en = 1'b1;

    // Directed: 64/10/8 byte payloads, header-only, then back-to-back with tuser on the middle.
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    send_frame(DEST, SRC, TYPE, pl, 1'b0, 1'b0, -1);
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'hA0 + i));
    send_frame(DEST, SRC, TYPE, pl, 1'b0, 1'b0, -1);
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'hC0 + i));
    send_frame(DEST, SRC, TYPE, pl, 1'b0, 1'b0, -1);
    pl = {};
    send_frame(DEST, SRC, 16'h88B5, pl, 1'b0, 1'b0, -1);
    for (int f = 0; f < 3; f++) begin
      pl = {};
      for (int i = 0; i < 13 + 7 * f; i++) pl.push_back(8'($urandom));
      send_frame(48'({$urandom, $urandom}), SRC, TYPE, pl, (f == 1), 1'b0, -1);
    end
    drain();
    check("gap", gap_cnt, 0);
    check("busy_idle", busy, 1'b0);
    gap_en = 1'b0;

    // Reset in the middle of a frame, then a clean frame must follow.
    mon_en = 1'b0;
    pl = {};
    for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
    send_frame(DEST, SRC, TYPE, pl, 1'b0, 1'b0, 3);
    check("rst_hdr_ready_low", s_hdr_ready, 1'b0);
    @(negedge clk);
    exp_q = {};
    mon_en = 1'b1;
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'(i));
    send_frame(DEST, SRC, TYPE, pl, 1'b1, 1'b0, -1);
    drain();

    // Random backpressure and payload gaps.
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 200);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_frame(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom),
                 pl, 1'($urandom_range(0, 1)), 1'b1, -1);
    end
    drain();
    check("busy_end", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
